// File: rtl/pairing_exec_seq.sv
`timescale 1ns/1ps
// pairing_exec_seq: drives the pairing core through Miller loop and/or final exponentiation
// and streams the 12-word Fp12 result. Define PAIRING_SEQ_CYCCNT_EN to add the exec_cycles counter.
module pairing_exec_seq #(
   parameter int unsigned MODE_W     = 2,
   parameter int unsigned MODE_IDLE  = 0,
   parameter int unsigned MODE_EXEC  = 2,
   parameter int unsigned MODE_REF   = 3,
   parameter int unsigned INST_W     = 2,
   parameter int unsigned INST_ML    = 0,
   parameter int unsigned INST_FE    = 1,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned WORD_W     = 256,
   parameter int unsigned RES_BASE   = 0,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned LAUNCH_TMO = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [MODE_W-1:0] core_mode,
   output logic [INST_W-1:0] core_inst,
   input  logic              core_busy,
   output logic [ADDR_W-1:0] core_raddr1,
   output logic [ADDR_W-1:0] core_raddr2,
   input  logic [WORD_W-1:0] core_rdata1,
   input  logic [WORD_W-1:0] core_rdata2,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [WORD_W-1:0] res_data1,
   output logic [WORD_W-1:0] res_data2,
   output logic [2:0]        res_idx
`ifdef PAIRING_SEQ_CYCCNT_EN
   ,
   output logic [31:0]       exec_cycles
`endif
);

   localparam int unsigned TMO_W    = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO + 1) : 1;
   localparam int unsigned LAT_W    = $clog2(RD_LAT + 1);
   localparam int unsigned NPAIR    = 6;
   localparam logic [2:0]  LAST_IDX = 3'(NPAIR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_READ,
      S_HOLD,
      S_DONE
   } state_t;

   state_t           state;
   logic             phase_fe;
   logic             op_hi;
   logic [TMO_W-1:0] tmo_cnt;
   logic [LAT_W-1:0] lat_cnt;

   // Result word address for pair idx; odd selects word 2k+1. Wraps at ADDR_W.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [2:0] idx, input logic odd);
      return ADDR_W'(RES_BASE) + ADDR_W'({idx, odd});
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         phase_fe    <= 1'b0;
         op_hi       <= 1'b0;
         tmo_cnt     <= '0;
         lat_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         res_valid   <= 1'b0;
         res_idx     <= 3'd0;
         res_data1   <= '0;
         res_data2   <= '0;
         core_mode   <= MODE_W'(MODE_IDLE);
         core_inst   <= INST_W'(INST_ML);
         core_raddr1 <= ADDR_W'(RES_BASE);
         core_raddr2 <= ADDR_W'(RES_BASE);
`ifdef PAIRING_SEQ_CYCCNT_EN
         exec_cycles <= 32'd0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

`ifdef PAIRING_SEQ_CYCCNT_EN
         // Saturating count of cycles spent launching or running the core.
         if ((state == S_LAUNCH || state == S_RUN) && exec_cycles != 32'hFFFF_FFFF)
            exec_cycles <= exec_cycles + 32'd1;
`endif

         case (state)
            S_IDLE: begin
               if (start && op != 2'b00) begin
                  state     <= S_LAUNCH;
                  busy      <= 1'b1;
                  phase_fe  <= ~op[0];
                  op_hi     <= op[1];
                  tmo_cnt   <= '0;
                  res_idx   <= 3'd0;
                  core_mode <= MODE_W'(MODE_EXEC);
                  core_inst <= op[0] ? INST_W'(INST_ML) : INST_W'(INST_FE);
`ifdef PAIRING_SEQ_CYCCNT_EN
                  exec_cycles <= 32'd0;
`endif
               end
            end

            S_LAUNCH: begin
               if (core_busy) begin
                  state <= S_RUN;
               end else if (tmo_cnt == TMO_W'(LAUNCH_TMO - 1)) begin
                  // Core never acknowledged the launch: abort without a result stream.
                  state     <= S_DONE;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  core_mode <= MODE_W'(MODE_IDLE);
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end

            S_RUN: begin
               if (!core_busy) begin
                  if (!phase_fe && op_hi) begin
                     state     <= S_LAUNCH;
                     phase_fe  <= 1'b1;
                     tmo_cnt   <= '0;
                     core_inst <= INST_W'(INST_FE);
                  end else begin
                     state       <= S_READ;
                     lat_cnt     <= '0;
                     res_idx     <= 3'd0;
                     core_mode   <= MODE_W'(MODE_REF);
                     core_raddr1 <= word_addr(3'd0, 1'b0);
                     core_raddr2 <= word_addr(3'd0, 1'b1);
                  end
               end
            end

            S_READ: begin
               // Address has been presented since entry; data lands RD_LAT cycles later.
               if (lat_cnt == LAT_W'(RD_LAT)) begin
                  state     <= S_HOLD;
                  res_valid <= 1'b1;
                  res_data1 <= core_rdata1;
                  res_data2 <= core_rdata2;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end

            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (res_idx == LAST_IDX) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     core_mode <= MODE_W'(MODE_IDLE);
                  end else begin
                     state       <= S_READ;
                     lat_cnt     <= '0;
                     res_idx     <= 3'(res_idx + 3'd1);
                     core_raddr1 <= word_addr(3'(res_idx + 3'd1), 1'b0);
                     core_raddr2 <= word_addr(3'(res_idx + 3'd1), 1'b1);
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pairing_exec_seq.sv
`timescale 1ns/1ps
// tb_pairing_exec_seq: core/RAM model, randomized sequences and a per-cycle behavioural checker.
module tb_pairing_exec_seq;

   localparam int unsigned MODE_W     = 2;
   localparam int unsigned MODE_IDLE  = 0;
   localparam int unsigned MODE_EXEC  = 2;
   localparam int unsigned MODE_REF   = 3;
   localparam int unsigned INST_W     = 2;
   localparam int unsigned INST_ML    = 0;
   localparam int unsigned INST_FE    = 1;
   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned WORD_W     = 256;
   localparam int unsigned RES_BASE   = 1018;
   localparam int unsigned RD_LAT     = 1;
   localparam int unsigned LAUNCH_TMO = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        op;
   logic              busy;
   logic              done;
   logic              err;
   logic [MODE_W-1:0] core_mode;
   logic [INST_W-1:0] core_inst;
   logic              core_busy = 1'b0;
   logic [ADDR_W-1:0] core_raddr1;
   logic [ADDR_W-1:0] core_raddr2;
   logic [WORD_W-1:0] core_rdata1;
   logic [WORD_W-1:0] core_rdata2;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [WORD_W-1:0] res_data1;
   logic [WORD_W-1:0] res_data2;
   logic [2:0]        res_idx;
`ifdef PAIRING_SEQ_CYCCNT_EN
   logic [31:0]       exec_cycles;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pairing_exec_seq #(
      .MODE_W(MODE_W), .MODE_IDLE(MODE_IDLE), .MODE_EXEC(MODE_EXEC), .MODE_REF(MODE_REF),
      .INST_W(INST_W), .INST_ML(INST_ML), .INST_FE(INST_FE), .ADDR_W(ADDR_W),
      .WORD_W(WORD_W), .RES_BASE(RES_BASE), .RD_LAT(RD_LAT), .LAUNCH_TMO(LAUNCH_TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy), .done(done), .err(err),
      .core_mode(core_mode), .core_inst(core_inst), .core_busy(core_busy),
      .core_raddr1(core_raddr1), .core_raddr2(core_raddr2),
      .core_rdata1(core_rdata1), .core_rdata2(core_rdata2),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data1(res_data1), .res_data2(res_data2), .res_idx(res_idx)
`ifdef PAIRING_SEQ_CYCCNT_EN
      , .exec_cycles(exec_cycles)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Result RAM contents: a function of address and a per-sequence salt.
   logic [31:0] salt = 32'h1234_5678;
   function automatic logic [WORD_W-1:0] ram_word(input logic [ADDR_W-1:0] a, input logic [31:0] s);
      logic [31:0] w;
      w = (32'(a) * 32'h9E37_79B9) ^ s;
      return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1, s, 32'(a), w, ~s};
   endfunction

   logic [WORD_W-1:0] d1_q [RD_LAT];
   logic [WORD_W-1:0] d2_q [RD_LAT];
   always @(posedge clk) begin
      d1_q[0] <= ram_word(core_raddr1, salt);
      d2_q[0] <= ram_word(core_raddr2, salt);
      for (int i = 1; i < int'(RD_LAT); i++) begin
         d1_q[i] <= d1_q[i-1];
         d2_q[i] <= d2_q[i-1];
      end
   end
   assign core_rdata1 = d1_q[RD_LAT-1];
   assign core_rdata2 = d2_q[RD_LAT-1];

   // Core model: after seeing EXEC for cm_delay+1 edges it is busy for cm_len cycles.
   // A change of instruction while still in EXEC re-arms it for the next phase.
   int unsigned       cm_delay = 2;
   int unsigned       cm_len   = 100;
   bit                cm_never = 1'b0;
   int                cm_cnt   = 0;
   int                cm_st    = 0;
   logic [INST_W-1:0] cm_inst  = '0;
   always @(posedge clk) begin
      if (core_mode != MODE_W'(MODE_EXEC)) begin
         cm_st = 0;
         cm_cnt = 0;
         core_busy <= 1'b0;
      end else begin
         case (cm_st)
            0: if (!cm_never) begin
                  if (cm_cnt >= int'(cm_delay)) begin
                     core_busy <= 1'b1;
                     cm_st = 1;
                     cm_cnt = 0;
                     cm_inst = core_inst;
                  end else cm_cnt++;
               end
            1: if (cm_cnt >= int'(cm_len) - 1) begin
                  core_busy <= 1'b0;
                  cm_st = 2;
               end else cm_cnt++;
            default: if (core_inst != cm_inst) begin
                  cm_st = 0;
                  cm_cnt = 0;
               end
         endcase
      end
   end

   // Consumer: 0 random, 1 always ready, 2 never ready, 3 ready except a stall on pair 3.
   int ready_mode = 1;
   int stall_left = 0;
   always @(negedge clk) begin
      #1;
      case (ready_mode)
         0: res_ready = ($urandom_range(0, 3) != 0);
         1: res_ready = 1'b1;
         2: res_ready = 1'b0;
         default: begin
            if (res_valid && res_idx == 3'd3 && stall_left > 0) begin
               res_ready = 1'b0;
               stall_left--;
            end else res_ready = 1'b1;
         end
      endcase
   end

   // Behavioural checker. At each negedge the inputs seen are those sampled at the preceding posedge.
   logic              pv_busy = 1'b0, pv_done = 1'b0, pv_valid = 1'b0, pv_cb = 1'b0;
   logic [2:0]        pv_idx = '0;
   logic [WORD_W-1:0] pv_d1 = '0, pv_d2 = '0;
   bit                active = 1'b0, exp_fe = 1'b0, exp_err = 1'b0;
   logic [1:0]        exp_op = 2'b00;
   int                beats = 0, exec_cnt = 0, read_cnt = 0, last_exec = 0, n_done = 0;

   always @(negedge clk) begin
      logic [ADDR_W-1:0] ea1, ea2;
      if (rst) begin
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_done", 64'(done), 64'(0));
         chk("rst_err", 64'(err), 64'(0));
         chk("rst_valid", 64'(res_valid), 64'(0));
         chk("rst_idx", 64'(res_idx), 64'(0));
         chkw("rst_data1", res_data1, '0);
         chkw("rst_data2", res_data2, '0);
         chk("rst_mode", 64'(core_mode), 64'(MODE_IDLE));
         chk("rst_inst", 64'(core_inst), 64'(INST_ML));
         chk("rst_raddr1", 64'(core_raddr1), 64'(ADDR_W'(RES_BASE)));
         chk("rst_raddr2", 64'(core_raddr2), 64'(ADDR_W'(RES_BASE)));
`ifdef PAIRING_SEQ_CYCCNT_EN
         chk("rst_exec_cycles", 64'(exec_cycles), 64'(0));
`endif
         active = 1'b0;
         pv_busy = 1'b0;
         pv_done = 1'b0;
         pv_valid = 1'b0;
      end else begin
         if (pv_valid) begin
            if (res_ready) begin
               beats++;
               chk("valid_drop_after_xfer", 64'(res_valid), 64'(0));
            end else begin
               chk("valid_hold", 64'(res_valid), 64'(1));
               chk("idx_hold", 64'(res_idx), 64'(pv_idx));
               chkw("data1_hold", res_data1, pv_d1);
               chkw("data2_hold", res_data2, pv_d2);
            end
         end
         if (!active && start && op != 2'b00 && !pv_busy && !pv_done) begin
            chk("busy_rise", 64'(busy), 64'(1));
            active = 1'b1;
            exp_op = op;
            exp_fe = !op[0];
            exp_err = cm_never;
            beats = 0;
            exec_cnt = 0;
            read_cnt = 0;
         end
         if (active) begin
            if (done) begin
               chk("done_busy_low", 64'(busy), 64'(0));
               chk("done_mode_idle", 64'(core_mode), 64'(MODE_IDLE));
               chk("done_err", 64'(err), 64'(exp_err));
               chk("done_valid_low", 64'(res_valid), 64'(0));
               chk("beats", 64'(beats), exp_err ? 64'(0) : 64'(6));
               chk("read_cycles", 64'(read_cnt), exp_err ? 64'(0) : 64'(6 * (RD_LAT + 1)));
               if (exp_err) chk("tmo_cycles", 64'(exec_cnt), 64'(LAUNCH_TMO));
`ifdef PAIRING_SEQ_CYCCNT_EN
               chk("exec_cycles", 64'(exec_cycles), 64'(exec_cnt));
`endif
               last_exec = exec_cnt;
               n_done++;
               active = 1'b0;
            end else begin
               chk("busy_held", 64'(busy), 64'(1));
               chk("err_quiet", 64'(err), 64'(0));
               if (core_mode == MODE_W'(MODE_EXEC)) begin
                  exec_cnt++;
                  chk("core_inst", 64'(core_inst), exp_fe ? 64'(INST_FE) : 64'(INST_ML));
               end else if (core_mode == MODE_W'(MODE_REF)) begin
                  chk("stream_after_last_phase", 64'(exp_fe), 64'(exp_op[1]));
                  if (!res_valid) read_cnt++;
                  else begin
                     ea1 = ADDR_W'(RES_BASE + 2 * beats);
                     ea2 = ADDR_W'(RES_BASE + 2 * beats + 1);
                     chk("res_idx", 64'(res_idx), 64'(beats));
                     chk("raddr1", 64'(core_raddr1), 64'(ea1));
                     chk("raddr2", 64'(core_raddr2), 64'(ea2));
                     chkw("res_data1", res_data1, ram_word(ea1, salt));
                     chkw("res_data2", res_data2, ram_word(ea2, salt));
                  end
               end else begin
                  chk("mode_while_busy", 64'(core_mode), 64'(MODE_EXEC));
               end
               if (pv_cb && !core_busy && !exp_fe && exp_op[1]) exp_fe = 1'b1;
            end
         end else begin
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_done", 64'(done), 64'(0));
            chk("idle_err", 64'(err), 64'(0));
            chk("idle_valid", 64'(res_valid), 64'(0));
            chk("idle_mode", 64'(core_mode), 64'(MODE_IDLE));
         end
         pv_busy = busy;
         pv_done = done;
         pv_valid = res_valid;
      end
      pv_cb = core_busy;
      pv_idx = res_idx;
      pv_d1 = res_data1;
      pv_d2 = res_data2;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] o);
      tick(1);
      start = 1'b1;
      op = o;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_reset(input int n);
      tick(1);
      rst = 1'b1;
      tick(n);
      rst = 1'b0;
   endtask

   // Waits for done (bounded); optionally pokes start while DONE is showing.
   task automatic wait_done(input int limit, input bit poke);
      int n;
      int d0;
      n = 0;
      d0 = n_done;
      while (done !== 1'b1 && n < limit) begin
         tick(1);
         n++;
      end
      if (poke) begin
         start = 1'b1;
         op = 2'b11;
      end
      tick(1);
      start = 1'b0;
      chk("one_done_per_seq", 64'(n_done - d0), 64'(1));
      if (n_done == d0) do_reset(2);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      op = 2'b00;
      tick(3);
      rst = 1'b0;
      tick(2);

      // ML only; a start during RUN and one during DONE must both be ignored.
      cm_delay = 2; cm_len = 100; ready_mode = 1; salt = $urandom;
      do_start(2'b01);
      tick(30);
      start = 1'b1; op = 2'b10;
      tick(1);
      start = 1'b0;
      wait_done(400, 1'b1);
      chk("pin_ml_exec_cycles", 64'(last_exec), 64'(104));

      // start with op=00 is ignored.
      start = 1'b1; op = 2'b00;
      tick(1);
      start = 1'b0;
      tick(3);

      // ML then FE, random consumer.
      ready_mode = 0; salt = $urandom;
      do_start(2'b11);
      wait_done(800, 1'b0);
      chk("pin_mlfe_exec_cycles", 64'(last_exec), 64'(209));

      // FE only with a 20-cycle consumer stall on pair 3.
      cm_delay = 0; cm_len = 5; ready_mode = 3; stall_left = 20; salt = $urandom;
      do_start(2'b10);
      wait_done(200, 1'b0);
      chk("stall_consumed", 64'(stall_left), 64'(0));

      // Core never acknowledges: timeout error, no beats.
      cm_never = 1'b1; ready_mode = 1;
      do_start(2'b01);
      wait_done(100, 1'b0);
      chk("pin_tmo_exec_cycles", 64'(last_exec), 64'(LAUNCH_TMO));
      cm_never = 1'b0;

      // Reset mid-RUN, then a fresh sequence.
      cm_delay = 2; cm_len = 100;
      do_start(2'b01);
      tick(40);
      do_reset(1);
      tick(5);
      cm_len = 8; salt = $urandom;
      do_start(2'b10);
      wait_done(300, 1'b0);

      // Reset mid-HOLD, then a fresh sequence.
      ready_mode = 2; cm_len = 3;
      do_start(2'b01);
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      chk("hold_reached", 64'(res_valid), 64'(1));
      tick(3);
      do_reset(1);
      tick(3);
      ready_mode = 0; salt = $urandom;
      do_start(2'b11);
      wait_done(400, 1'b0);

      // Randomized sequences.
      for (int i = 0; i < 25; i++) begin
         cm_delay = $urandom_range(0, 6);
         cm_len = $urandom_range(1, 30);
         cm_never = ($urandom_range(0, 7) == 0);
         ready_mode = 0;
         salt = $urandom;
         do_start(2'($urandom_range(1, 3)));
         wait_done(2000, 1'b0);
         tick($urandom_range(0, 3));
      end
      cm_never = 1'b0;

      tick(2);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d bad=%0d", n_chk, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
